// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads to
// instruction memory and queues the returned words with their PCs for decode.
// A redirect flushes the queue and remembers how many responses are still in
// flight so that those stale words are dropped when they come back.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_CMP = (CNT_W+1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PTR_W-1:0] alloc_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;    // allocated entries
  logic [CNT_W-1:0] pend;     // allocated entries still waiting for data
  logic [CNT_W-1:0] discard;  // stale responses still to be dropped
  logic [CNT_W:0]   occupancy;

  logic head_ok;
  logic req_fire;
  logic pop;
  logic rsp_drop;
  logic rsp_fill;
  logic fill_we;
  logic unused_pc_bits;

  // Low address bits of a redirect target are meaningless for word fetch.
  assign unused_pc_bits = &redirect_pc[1:0];

  // Every allocated entry and every pending discard holds one slot of the
  // outstanding-request budget; requests stop when the budget is used up.
  assign occupancy      = {1'b0, count} + {1'b0, discard};
  assign imem_req_valid = reset && !redirect_valid && (occupancy < DEPTH_CMP);
  assign imem_req_addr  = fetch_pc;

  assign head_ok    = (count != '0) && filled[rd_ptr];
  assign inst_valid = !redirect_valid && head_ok;
  assign inst_data  = head_ok ? data_q[rd_ptr] : 32'h0;
  assign inst_pc    = head_ok ? pc_q[rd_ptr]   : 32'h0;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = inst_valid && inst_ready;
  assign rsp_drop = imem_rsp_valid && (discard != '0);
  assign rsp_fill = imem_rsp_valid && (discard == '0) && (pend != '0);
  assign fill_we  = rsp_fill && !redirect_valid;

  // Control state: fetch PC, queue pointers, occupancy and discard tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      filled    <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend      <= '0;
      discard   <= '0;
    end else if (redirect_valid) begin
      // A response landing in the redirect cycle is stale and consumes one
      // of the outstanding slots now.
      fetch_pc  <= {redirect_pc[31:2], 2'b00};
      filled    <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend      <= '0;
      discard   <= discard + pend - CNT_W'(rsp_drop || rsp_fill);
    end else begin
      if (req_fire) begin
        alloc_ptr         <= alloc_ptr + PTR_W'(1);
        fetch_pc          <= fetch_pc + 32'd4;
        filled[alloc_ptr] <= 1'b0;
      end
      if (rsp_fill) begin
        fill_ptr         <= fill_ptr + PTR_W'(1);
        filled[fill_ptr] <= 1'b1;
      end
      if (rsp_drop) begin
        discard <= discard - CNT_W'(1);
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        filled[rd_ptr] <= 1'b0;
      end
      count <= count + CNT_W'(req_fire) - CNT_W'(pop);
      pend  <= pend + CNT_W'(req_fire) - CNT_W'(rsp_fill);
    end
  end

  // Queue payload: PC captured on request acceptance, word on response.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_q[alloc_ptr] <= fetch_pc;
    end
    if (fill_we) begin
      data_q[fill_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a queue-level model of the fetch stage and a
// latency-programmable memory drive two DUTs (RESET_PC 0 and FFFF_FFF8) with
// directed stimulus; outputs are compared every cycle plus literal pins.
module tb_instruction_fetch;

  localparam logic [31:0] PC2 = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_ready = 1'b0;

  logic        imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst_data, inst_pc;
  logic        imem_req_valid2, inst_valid2;
  logic [31:0] imem_req_addr2, inst_data2, inst_pc2;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  instruction_fetch #(.RESET_PC(PC2), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid2), .imem_req_addr(imem_req_addr2),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid2), .inst_data(inst_data2), .inst_pc(inst_pc2),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ent_t        mq[$];      // model fetch queue
  mreq_t       memq[$];    // memory: accepted requests awaiting response
  int          m_disc;
  logic [31:0] m_fetch;
  logic [31:0] off2;       // dut2 address offset until its first redirect
  int          cyc = 0;
  int          lat_lo = 1, lat_hi = 1;

  logic [31:0] obs_pc[$], obs_data[$], obs_cyc[$], req_log[$], req2_log[$];
  int n_pass = 0, n_chk = 0;
  int m0, r0, r2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive inputs, compare both DUTs with the model, log the
  // DUT handshakes, then advance model and memory to the next cycle.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit ird, input bit rrdy);
    bit e_req, e_inst, hs_req, hs_pop, done;
    logic [31:0] e_pc, e_data;
    int unf;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = ird;
    imem_req_ready = rrdy;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr ^ KEY;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    e_req  = !redir && (mq.size() + m_disc < 4);
    e_inst = !redir && mq.size() > 0 && mq[0].filled;
    e_pc   = e_inst ? mq[0].pc   : 32'h0;
    e_data = e_inst ? mq[0].data : 32'h0;
    chk("req_valid", imem_req_valid, e_req);
    if (e_req) chk("req_addr", imem_req_addr, m_fetch);
    chk("inst_valid", inst_valid, e_inst);
    if (e_inst) begin
      chk("inst_pc", inst_pc, e_pc);
      chk("inst_data", inst_data, e_data);
    end
    chk("req_valid2", imem_req_valid2, e_req);
    if (e_req) chk("req_addr2", imem_req_addr2, m_fetch + off2);
    chk("inst_valid2", inst_valid2, e_inst);
    if (e_inst) begin
      chk("inst_pc2", inst_pc2, e_pc + off2);
      chk("inst_data2", inst_data2, e_data);
    end
    if (imem_req_valid && rrdy) req_log.push_back(imem_req_addr);
    if (imem_req_valid2 && rrdy) req2_log.push_back(imem_req_addr2);
    if (inst_valid && ird) begin
      obs_pc.push_back(inst_pc);
      obs_data.push_back(inst_data);
      obs_cyc.push_back(32'(cyc));
    end
    hs_req = e_req && rrdy;
    hs_pop = e_inst && ird;
    if (redir) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      m_disc = m_disc + unf - ((imem_rsp_valid && (m_disc + unf > 0)) ? 1 : 0);
      mq.delete();
      m_fetch = {rpc[31:2], 2'b00};
      off2 = 32'h0;
    end else begin
      if (imem_rsp_valid) begin
        if (m_disc > 0) m_disc--;
        else begin
          done = 1'b0;
          foreach (mq[i]) if (!done && !mq[i].filled) begin
            mq[i].filled = 1'b1;
            mq[i].data   = imem_rsp_data;
            done = 1'b1;
          end
        end
      end
      if (hs_pop) void'(mq.pop_front());
      if (hs_req) begin
        mq.push_back('{m_fetch, 32'h0, 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
    if (imem_rsp_valid) void'(memq.pop_front());
    if (imem_req_valid && rrdy)
      memq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_model();
    mq.delete();
    memq.delete();
    m_disc  = 0;
    m_fetch = 32'h0;
    off2    = PC2;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    clear_model();
    @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 32'h0);
    chk("rst_inst_valid", inst_valid, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_req_valid2", imem_req_valid2, 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Straight-line fetch, 1-cycle memory, decode always ready.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    m0 = obs_pc.size(); r0 = req_log.size();
    repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t1_req0", at(req_log, r0), 32'h0);
    chk("t1_req1", at(req_log, r0 + 1), 32'h4);
    chk("t1_req2", at(req_log, r0 + 2), 32'h8);
    chk("t1_pc0", at(obs_pc, m0), 32'h0);
    chk("t1_pc1", at(obs_pc, m0 + 1), 32'h4);
    chk("t1_pc2", at(obs_pc, m0 + 2), 32'h8);
    chk("t1_data1", at(obs_data, m0 + 1), 32'hA5A5_A5A1);
    chk("t1_back2back1", at(obs_cyc, m0 + 1), at(obs_cyc, m0) + 32'd1);
    chk("t1_back2back2", at(obs_cyc, m0 + 2), at(obs_cyc, m0) + 32'd2);

    // Decode stall: queue fills to DEPTH, requests stop, head held.
    do_reset();
    r0 = req_log.size();
    repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t2_req_count", 32'(req_log.size() - r0), 32'd4);
    chk("t2_req_valid_low", imem_req_valid, 32'h0);
    chk("t2_head_valid", inst_valid, 32'h1);
    chk("t2_head_pc", inst_pc, 32'h0);
    m0 = obs_pc.size();
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) chk("t2_release_pc", at(obs_pc, m0 + i), 32'(4 * i));

    // Toggling memory ready, 1..3 cycle latency, intermittent decode stalls.
    lat_lo = 1; lat_hi = 3;
    do_reset();
    m0 = obs_pc.size();
    repeat (80) cycle(1'b0, 32'h0, $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1);
    for (int i = 0; i < 16; i++) begin
      chk("t3_order_pc", at(obs_pc, m0 + i), 32'(4 * i));
      chk("t3_order_data", at(obs_data, m0 + i), 32'(4 * i) ^ KEY);
    end

    // Redirect with three requests in flight (4-cycle memory).
    lat_lo = 4; lat_hi = 4;
    do_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    m0 = obs_pc.size(); r0 = req_log.size();
    cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t4_next_req", at(req_log, r0), 32'h0000_0100);
    chk("t4_first_pc", at(obs_pc, m0), 32'h0000_0100);
    chk("t4_first_data", at(obs_data, m0), 32'hA5A5_A4A5);

    // Redirect colliding with a response and a decode handshake.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t5_pre_valid", inst_valid, 32'h1);
    m0 = obs_pc.size();
    cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    chk("t5_no_pop", 32'(obs_pc.size() - m0), 32'h0);
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t5_first_pc", at(obs_pc, m0), 32'h0000_0200);
    chk("t5_second_pc", at(obs_pc, m0 + 1), 32'h0000_0204);

    // Address wrap through redirect, then back-to-back redirects.
    m0 = obs_pc.size();
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_wrap0", at(obs_pc, m0), 32'hFFFF_FFF8);
    chk("t6_wrap1", at(obs_pc, m0 + 1), 32'hFFFF_FFFC);
    chk("t6_wrap2", at(obs_pc, m0 + 2), 32'h0000_0000);
    m0 = obs_pc.size();
    cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0400, 1'b1, 1'b1);
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t7_first_pc", at(obs_pc, m0), 32'h0000_0400);

    // Asynchronous reset mid-stream, then refetch from each RESET_PC.
    chk("t8_pre_valid", inst_valid, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("t8_req_valid", imem_req_valid, 32'h0);
    chk("t8_inst_valid", inst_valid, 32'h0);
    chk("t8_req_valid2", imem_req_valid2, 32'h0);
    chk("t8_inst_valid2", inst_valid2, 32'h0);
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    r0 = req_log.size(); r2 = req2_log.size(); m0 = obs_pc.size();
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t8_refetch", at(req_log, r0), 32'h0);
    chk("t8_first_pc", at(obs_pc, m0), 32'h0);
    chk("t8_rpc2_0", at(req2_log, r2), 32'hFFFF_FFF8);
    chk("t8_rpc2_1", at(req2_log, r2 + 1), 32'hFFFF_FFFC);
    chk("t8_rpc2_2", at(req2_log, r2 + 2), 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
